// File: rtl/ram16_pkg.sv
// ram16_pkg: types and constants shared by the ram16 block.
//   DATA_WIDTH : width of one stored word
//   word_t     : one RAM word
package ram16_pkg;

    localparam int DATA_WIDTH = 16;

    typedef logic [DATA_WIDTH-1:0] word_t;

endpackage : ram16_pkg

// File: rtl/ram16_wr_counter.sv
// ram16_wr_counter: counts accepted writes modulo 2^ADDR_WIDTH and emits a
// one-cycle FULL pulse after every 2^ADDR_WIDTH-th write.
// Ports:
//   CLK   : clock, rising edge
//   RST   : synchronous active-high reset (clears count and FULL)
//   WRITE : write accepted this edge
//   FULL  : registered pulse, high for the cycle after the wrapping write
module ram16_wr_counter #(
    parameter int ADDR_WIDTH = 3
) (
    input  logic CLK,
    input  logic RST,
    input  logic WRITE,
    output logic FULL
);

    // All-ones is DEPTH-1 for a power-of-two depth.
    localparam logic [ADDR_WIDTH-1:0] WCNT_LAST = '1;
    localparam logic [ADDR_WIDTH-1:0] WCNT_ONE  = ADDR_WIDTH'(1);

    logic [ADDR_WIDTH-1:0] wcnt_reg;
    logic                  full_reg;

    always_ff @(posedge CLK) begin
        if (RST) begin
            wcnt_reg <= '0;
            full_reg <= 1'b0;
        end else if (WRITE) begin
            if (wcnt_reg == WCNT_LAST) begin
                wcnt_reg <= '0;
                full_reg <= 1'b1;
            end else begin
                wcnt_reg <= wcnt_reg + WCNT_ONE;
                full_reg <= 1'b0;
            end
        end else begin
            // Idle and read cycles keep the count; only the pulse drops.
            full_reg <= 1'b0;
        end
    end

    assign FULL = full_reg;

endmodule : ram16_wr_counter

// File: rtl/ram16.sv
// ram16: single-port 16-bit RAM of 2^ADDR_WIDTH words with a registered read
// port and a write-count monitor.
// Ports:
//   CLK   : clock, all state changes on the rising edge
//   RST   : synchronous active-high reset; clears every word, Do, FULL, count
//   READ  : read enable; Do <= RAM[A] at the edge
//   WRITE : write enable; RAM[A] <= Di at the edge
//   A     : word address shared by read and write
//   Di    : write data
//   Do    : registered read data, holds when READ=0
//   FULL  : one-cycle pulse after every DEPTH-th accepted write
module ram16
    import ram16_pkg::*;
#(
    parameter int ADDR_WIDTH = 3
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  READ,
    input  logic                  WRITE,
    input  logic [ADDR_WIDTH-1:0] A,
    input  logic [15:0]           Di,
    output logic [15:0]           Do,
    output logic                  FULL
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    // Name is relied on by hierarchical memory dumps.
    word_t RAM [0:DEPTH-1];
    word_t do_reg;

    // Read and write share one edge; the non-blocking update makes a
    // same-address READ+WRITE return the old word (read-first).
    // The reset clear of every word means this maps to registers, not a
    // block RAM primitive.
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < DEPTH; i++) begin
                RAM[i] <= '0;
            end
            do_reg <= '0;
        end else begin
            if (WRITE) begin
                RAM[A] <= Di;
            end
            if (READ) begin
                do_reg <= RAM[A];
            end
        end
    end

    assign Do = do_reg;

    ram16_wr_counter #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_wr_counter (
        .CLK   (CLK),
        .RST   (RST),
        .WRITE (WRITE),
        .FULL  (FULL)
    );

endmodule : ram16

// File: tb/tb_ram16.sv
// tb_ram16: scoreboard bench for ram16 (ADDR_WIDTH=3). Each cycle's expected
// Do and FULL are pushed when stimulus is driven and popped after the edge.
module tb_ram16;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        READ = 1'b0;
    logic        WRITE = 1'b0;
    logic [2:0]  A = '0;
    logic [15:0] Di = '0;
    logic [15:0] Do;
    logic        FULL;

    ram16 #(.ADDR_WIDTH(3)) dut (
        .CLK   (CLK),
        .RST   (RST),
        .READ  (READ),
        .WRITE (WRITE),
        .A     (A),
        .Di    (Di),
        .Do    (Do),
        .FULL  (FULL)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [15:0] m_mem [0:7];
    logic [15:0] m_do = '0;
    logic [2:0]  m_cnt = '0;
    logic        m_full = 1'b0;

    logic [15:0] exp_do_q[$];
    logic        exp_full_q[$];

    int  full_rises = 0;
    logic full_prev = 1'b0;

    task automatic check(input string tag, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // One clock of stimulus; called just after a rising edge.
    task automatic step(input logic r, input logic rd, input logic wr,
                        input logic [2:0] a, input logic [15:0] di);
        logic [15:0] e_do;
        logic        e_full;
        RST = r; READ = rd; WRITE = wr; A = a; Di = di;
        if (r) begin
            for (int k = 0; k < 8; k++) m_mem[k] = '0;
            m_do = '0; m_cnt = '0; m_full = 1'b0;
        end else begin
            if (rd) m_do = m_mem[a];
            if (wr) begin
                m_full = (m_cnt == 3'd7);
                m_cnt = m_cnt + 3'd1;
                m_mem[a] = di;
            end else begin
                m_full = 1'b0;
            end
        end
        exp_do_q.push_back(m_do);
        exp_full_q.push_back(m_full);
        @(posedge CLK);
        #1;
        e_do = exp_do_q.pop_front();
        e_full = exp_full_q.pop_front();
        check($sformatf("do r=%0b rd=%0b wr=%0b a=%0d", r, rd, wr, a), Do, e_do);
        check($sformatf("full r=%0b wr=%0b a=%0d", r, wr, a), {15'd0, FULL}, {15'd0, e_full});
        if (FULL && !full_prev) full_rises++;
        full_prev = FULL;
        RST = 1'b0; READ = 1'b0; WRITE = 1'b0;
    endtask

    initial begin
        for (int k = 0; k < 8; k++) m_mem[k] = '0;
        @(posedge CLK);
        #1;

        // Reset for two cycles, then every word reads zero.
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        full_rises = 0;
        for (int k = 0; k < 8; k++) begin
            step(0, 1, 0, 3'(k), 0);
            check($sformatf("reset_rd a=%0d", k), Do, 16'h0000);
        end
        check("reset_full_rises", 16'(full_rises), 16'd0);

        // 32 separated writes, each read back after an idle cycle.
        full_rises = 0;
        for (int i = 0; i < 32; i++) begin
            logic [15:0] w;
            w = 16'hB000 + 16'(i);
            step(0, 0, 1, 3'(i % 8), w);
            step(0, 0, 0, 0, 0);
            step(0, 1, 0, 3'(i % 8), 0);
            check($sformatf("wrrd i=%0d", i), Do, w);
        end
        check("full_rises_32", 16'(full_rises), 16'd4);
        for (int k = 0; k < 8; k++) begin
            step(0, 1, 0, 3'(k), 0);
            check($sformatf("final a=%0d", k), Do, 16'hB018 + 16'(k));
        end

        // Hold: Do keeps the read of address 5 while other words change.
        step(0, 1, 0, 3'd5, 0);
        for (int j = 0; j < 4; j++) begin
            step(0, 0, 1, 3'(j), 16'hC000 + 16'(j));
            check($sformatf("hold j=%0d", j), Do, 16'hB01D);
        end

        // Read-first collision at address 3.
        step(0, 0, 1, 3'd3, 16'h1111);
        step(0, 1, 1, 3'd3, 16'h2222);
        check("collide_old", Do, 16'h1111);
        step(0, 1, 0, 3'd3, 0);
        check("collide_new", Do, 16'h2222);

        // Reset mid-count: 5 writes, reset, then 8 writes to addresses 0..3.
        for (int j = 0; j < 5; j++) step(0, 0, 1, 3'(j), 16'hD000 + 16'(j));
        step(1, 0, 0, 0, 0);
        full_rises = 0;
        for (int j = 0; j < 8; j++) begin
            step(0, 0, 1, 3'(j % 4), 16'hE000 + 16'(j));
            check($sformatf("rst_mid_full n=%0d", j + 1), {15'd0, FULL}, (j == 7) ? 16'd1 : 16'd0);
        end
        step(0, 0, 0, 0, 0);
        check("rst_mid_rises", 16'(full_rises), 16'd1);
        for (int k = 4; k < 8; k++) begin
            step(0, 1, 0, 3'(k), 0);
            check($sformatf("rst_mid_zero a=%0d", k), Do, 16'h0000);
        end
        for (int k = 0; k < 4; k++) begin
            step(0, 1, 0, 3'(k), 0);
            check($sformatf("rst_mid_data a=%0d", k), Do, 16'hE004 + 16'(k));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_ram16
